// File: rtl/replace_plru_n.sv
// Per-set victim selector: tree pseudo-LRU or LFSR random, with invalid-way priority.
// Victim result is registered one cycle after the query; touches update the tree at the edge.
module replace_plru_n #(
    parameter int WAYS = 4,
    parameter int SETS = 64,
    parameter int MODE = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     q_en,
    input  logic [$clog2(SETS)-1:0]  q_set,
    input  logic [WAYS-1:0]          q_valid_way,
    output logic                     v_valid,
    output logic [WAYS-1:0]          v_way,
    output logic [$clog2(WAYS)-1:0]  v_idx,
    input  logic                     t_en,
    input  logic [$clog2(SETS)-1:0]  t_set,
    input  logic [WAYS-1:0]          t_way
);

    localparam int IW = $clog2(WAYS);
    localparam int SW = $clog2(SETS);
    localparam int NB = WAYS - 1;

    logic [NB-1:0] plru [SETS];
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_nxt;
    logic [NB-1:0] cur;
    logic [NB-1:0] t_nxt;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] tree_idx;
    logic [IW-1:0] rnd_idx;
    logic [IW-1:0] vic_idx;
    logic [IW-1:0] t_idx;
    logic          free_hit;

    // Victim: lowest invalid way wins, otherwise walk the tree (or use the LFSR).
    always_comb begin
        int   node;
        logic b;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!q_valid_way[i]) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
        cur      = plru[q_set];
        tree_idx = '0;
        node     = 0;
        for (int l = 0; l < IW; l++) begin
            b = 1'b0;
            for (int n = 0; n < NB; n++) begin
                if (n == node) b = cur[n];
            end
            tree_idx = (tree_idx << 1) | IW'(b);
            node     = 2 * node + 1 + int'(b);
        end
        rnd_idx  = lfsr[IW-1:0];
        lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
        if (free_hit)       vic_idx = free_idx;
        else if (MODE == 1) vic_idx = rnd_idx;
        else                vic_idx = tree_idx;
    end

    // Touch: every node on the path flips to point away from the touched way.
    always_comb begin
        int   node;
        logic d;
        t_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (t_way[i]) t_idx = t_idx | IW'(i);
        end
        t_nxt = plru[t_set];
        node  = 0;
        for (int l = 0; l < IW; l++) begin
            d = t_idx[IW-1-l];
            for (int n = 0; n < NB; n++) begin
                if (n == node) t_nxt[n] = ~d;
            end
            node = 2 * node + 1 + int'(d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
            lfsr    <= 8'h01;
            v_valid <= 1'b0;
            v_way   <= WAYS'(1);
            v_idx   <= '0;
        end else begin
            v_valid <= q_en;
            if (q_en) begin
                v_idx <= vic_idx;
                v_way <= WAYS'(1) << vic_idx;
                if (MODE == 1) lfsr <= lfsr_nxt;
            end
            if (MODE == 0 && t_en) plru[t_set] <= t_nxt;
        end
    end

endmodule

// File: tb/tb_replace_plru_n.sv
// Directed bench for replace_plru_n: tree-PLRU instance and LFSR instance side by side.
module tb_replace_plru_n;

    logic       clock = 1'b0;
    logic       reset;
    logic       q_en;
    logic [5:0] q_set;
    logic [3:0] q_valid_way;
    logic       t_en;
    logic [5:0] t_set;
    logic [3:0] t_way;

    logic       a_valid, b_valid;
    logic [3:0] a_way, b_way;
    logic [1:0] a_idx, b_idx;

    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    replace_plru_n #(.WAYS(4), .SETS(64), .MODE(0)) u_tree (
        .clock(clock), .reset(reset),
        .q_en(q_en), .q_set(q_set), .q_valid_way(q_valid_way),
        .v_valid(a_valid), .v_way(a_way), .v_idx(a_idx),
        .t_en(t_en), .t_set(t_set), .t_way(t_way)
    );

    replace_plru_n #(.WAYS(4), .SETS(64), .MODE(1)) u_rand (
        .clock(clock), .reset(reset),
        .q_en(q_en), .q_set(q_set), .q_valid_way(q_valid_way),
        .v_valid(b_valid), .v_way(b_way), .v_idx(b_idx),
        .t_en(t_en), .t_set(t_set), .t_way(t_way)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        q_en = 1'b0; q_set = '0; q_valid_way = 4'hF;
        t_en = 1'b0; t_set = '0; t_way = 4'b0001;
    endtask

    task automatic query(input logic [5:0] s, input logic [3:0] vw);
        q_en = 1'b1; q_set = s; q_valid_way = vw;
        step();
        q_en = 1'b0;
    endtask

    task automatic touch(input logic [5:0] s, input logic [3:0] w);
        t_en = 1'b1; t_set = s; t_way = w;
        step();
        t_en = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (a_valid !== 1'b0 || a_way !== 4'b0001 || a_idx !== 2'd0) begin
            errs++;
            $display("FAIL reset_tree: got v=%b way=%b idx=%0d want v=0 way=0001 idx=0",
                     a_valid, a_way, a_idx);
        end
        vecs++;
        if (b_valid !== 1'b0 || b_way !== 4'b0001 || b_idx !== 2'd0) begin
            errs++;
            $display("FAIL reset_rand: got v=%b way=%b idx=%0d want v=0 way=0001 idx=0",
                     b_valid, b_way, b_idx);
        end
    endtask

    task automatic test_first_query();
        query(6'd5, 4'b1111);
        vecs++;
        if (a_valid !== 1'b1 || a_way !== 4'b0001 || a_idx !== 2'd0) begin
            errs++;
            $display("FAIL first_query: got v=%b way=%b idx=%0d want v=1 way=0001 idx=0",
                     a_valid, a_way, a_idx);
        end
        step();
        vecs++;
        if (a_valid !== 1'b0 || a_way !== 4'b0001) begin
            errs++;
            $display("FAIL valid_drop_hold: got v=%b way=%b want v=0 way=0001",
                     a_valid, a_way);
        end
    endtask

    task automatic test_touch();
        touch(6'd5, 4'b0001);
        query(6'd5, 4'b1111);
        vecs++;
        if (a_way !== 4'b0100 || a_idx !== 2'd2) begin
            errs++;
            $display("FAIL touch_way0: got way=%b idx=%0d want way=0100 idx=2", a_way, a_idx);
        end
        touch(6'd5, 4'b0100);
        query(6'd5, 4'b1111);
        vecs++;
        if (a_way !== 4'b0010 || a_idx !== 2'd1) begin
            errs++;
            $display("FAIL touch_way2: got way=%b idx=%0d want way=0010 idx=1", a_way, a_idx);
        end
    endtask

    task automatic test_free_way();
        query(6'd3, 4'b1011);
        vecs++;
        if (a_way !== 4'b0100 || a_idx !== 2'd2) begin
            errs++;
            $display("FAIL free_1011: got way=%b idx=%0d want way=0100 idx=2", a_way, a_idx);
        end
        query(6'd3, 4'b0000);
        vecs++;
        if (a_way !== 4'b0001 || a_idx !== 2'd0) begin
            errs++;
            $display("FAIL free_0000: got way=%b idx=%0d want way=0001 idx=0", a_way, a_idx);
        end
        query(6'd3, 4'b0111);
        vecs++;
        if (a_way !== 4'b1000 || a_idx !== 2'd3) begin
            errs++;
            $display("FAIL free_0111: got way=%b idx=%0d want way=1000 idx=3", a_way, a_idx);
        end
        // Set 5 tree now points at way 1; invalid way 3 still takes priority.
        query(6'd5, 4'b0111);
        vecs++;
        if (a_way !== 4'b1000) begin
            errs++;
            $display("FAIL free_over_tree: got way=%b want way=1000", a_way);
        end
        query(6'd3, 4'b1111);
        vecs++;
        if (a_way !== 4'b0001) begin
            errs++;
            $display("FAIL set3_unchanged: got way=%b want way=0001", a_way);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        q_en = 1'b1; q_set = 6'd7; q_valid_way = 4'b1111;
        t_en = 1'b1; t_set = 6'd7; t_way = 4'b0001;
        step();
        idle();
        vecs++;
        if (a_way !== 4'b0001 || a_valid !== 1'b1) begin
            errs++;
            $display("FAIL same_cycle_pre: got v=%b way=%b want v=1 way=0001", a_valid, a_way);
        end
        query(6'd7, 4'b1111);
        vecs++;
        if (a_way !== 4'b0100) begin
            errs++;
            $display("FAIL same_cycle_post: got way=%b want way=0100", a_way);
        end
        query(6'd0, 4'b1111);
        vecs++;
        if (a_way !== 4'b0001) begin
            errs++;
            $display("FAIL other_set0: got way=%b want way=0001", a_way);
        end
        query(6'd63, 4'b1111);
        vecs++;
        if (a_way !== 4'b0001) begin
            errs++;
            $display("FAIL other_set63: got way=%b want way=0001", a_way);
        end
    endtask

    task automatic test_back_to_back();
        // lfsr states 01,80,40,20,10,88,c4,e2,71 -> low two bits.
        logic [1:0] exp_idx [9] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            q_en = 1'b1; q_set = 6'(i); q_valid_way = 4'b1111;
            t_en = 1'b1; t_set = 6'(i); t_way = 4'b1000;
            step();
            idle();
            vecs++;
            if (b_valid !== 1'b1 || b_idx !== exp_idx[i] || b_way !== (4'b0001 << exp_idx[i])) begin
                errs++;
                $display("FAIL lfsr_q%0d: got v=%b idx=%0d way=%b want v=1 idx=%0d",
                         i, b_valid, b_idx, b_way, exp_idx[i]);
            end
            if (i == 4) begin
                step();
                step();
            end
        end
    endtask

    task automatic test_reset_pending();
        touch(6'd9, 4'b0001);
        q_en = 1'b1; q_set = 6'd9; q_valid_way = 4'b1111;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        vecs++;
        if (a_valid !== 1'b0 || a_way !== 4'b0001 || b_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_pending: got va=%b wa=%b vb=%b want 0 0001 0",
                     a_valid, a_way, b_valid);
        end
        query(6'd9, 4'b1111);
        vecs++;
        if (a_way !== 4'b0001) begin
            errs++;
            $display("FAIL post_reset_set9: got way=%b want way=0001", a_way);
        end
        query(6'd7, 4'b1111);
        vecs++;
        if (a_way !== 4'b0001) begin
            errs++;
            $display("FAIL post_reset_set7: got way=%b want way=0001", a_way);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_first_query();
        test_touch();
        test_free_way();
        test_same_cycle();
        test_back_to_back();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/replace_plru_n.md
REPLACE_PLRU_N -- requirements
Module: replace_plru_n

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity; legal values 2, 4, 8.
REQ-002 SHALL have parameter SETS, default 64: number of sets; power of two, 2..256.
REQ-003 SHALL have parameter MODE, default 0: 0 = tree-PLRU, 1 = LFSR random.
REQ-004 SHALL define derived localparams IW = log2(WAYS) and SW = log2(SETS).
REQ-005 SHALL have port clock  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port q_en  in  1  victim query request.
REQ-008 SHALL have port q_set  in  SW  set index of the query.
REQ-009 SHALL have port q_valid_way  in  WAYS  per-way valid bits of the queried set.
REQ-010 SHALL have port v_valid  out  1  victim result valid, registered.
REQ-011 SHALL have port v_way  out  WAYS  one-hot victim, registered.
REQ-012 SHALL have port v_idx  out  IW  binary index of v_way, registered.
REQ-013 SHALL have port t_en  in  1  touch (hit or fill) update request.
REQ-014 SHALL have port t_set  in  SW  set index of the touch.
REQ-015 SHALL have port t_way  in  WAYS  one-hot way touched; ignored when t_en=0.

Function
REQ-016 SHALL hold WAYS-1 PLRU bits per set, as a heap: node n has children 2n+1 (lower half) and 2n+2 (upper half); node 0 is the root.
REQ-017 SHALL read a PLRU bit of 0 as "victim in lower-index subtree" and 1 as "victim in upper-index subtree".
REQ-018 SHALL, on t_en=1 in MODE 0, set every node on the root-to-leaf path of t_way so it points away from t_way; all other nodes stay unchanged.
REQ-019 SHALL ignore t_en when MODE=1.
REQ-020 SHALL, on q_en=1, compute the victim from the current (pre-edge) state and register it, giving v_valid=1 exactly one cycle later.
REQ-021 SHALL drive v_valid=0 in any cycle not preceded by q_en=1; v_way and v_idx hold their last values when v_valid=0.
REQ-022 SHALL select the lowest-index way with q_valid_way=0 as victim if any exist, in both modes; PLRU/LFSR state is not consulted.
REQ-023 SHALL, when all q_valid_way bits are 1, select by traversing the tree from the root in MODE 0, or use way = lfsr[IW-1:0] in MODE 1.
REQ-024 SHALL implement lfsr as 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting toward bit 0, advancing once per cycle with q_en=1 (MODE 1 only); the victim uses the pre-advance value.
REQ-025 SHALL NOT modify PLRU state on a query; callers must issue a touch for the filled way.
REQ-026 SHALL, on q_en and t_en to the same set in the same cycle, base the query on the pre-touch state; the touch takes effect at the edge.
REQ-027 SHALL accept q_en and t_en independently every cycle with no back-pressure; throughput is one query and one touch per cycle.
REQ-028 SHALL treat an X-free q_set/t_set outside 0..SETS-1 as impossible, because widths are exact.
REQ-029 SHALL always produce a v_way that is exactly one-hot.

Reset
REQ-030 SHALL, while reset=1, clear all PLRU bits to 0, load lfsr with 8'h01, and drive v_valid=0, v_way=1 (way 0), and v_idx=0.
REQ-031 SHALL ignore q_en and t_en on a reset cycle; a query pending at reset produces no v_valid.
REQ-032 SHALL reach an all-PLRU-bits-zero state in a single reset cycle regardless of SETS.

Verification
REQ-033 SHALL pass: reset; WAYS=4, MODE=0; q_en, set 5, valid=4'b1111 -> next cycle v_valid=1, v_way=4'b0001, v_idx=0.
REQ-034 SHALL pass: touch set 5 way0, then query all-valid -> v_way=4'b0100; then touch way2, query -> v_way=4'b0010.
REQ-035 SHALL pass: query set 3, valid=4'b1011 -> v_way=4'b0100; valid=4'b0000 -> v_way=4'b0001; PLRU bits of set 3 unchanged.
REQ-036 SHALL pass: same-cycle query and touch of way0 on set 7 after reset -> v_way=4'b0001; next-cycle query -> 4'b0100; other sets still return 4'b0001.
REQ-037 SHALL pass: MODE=1, reset, three back-to-back all-valid queries -> v_idx sequence equals lfsr[1:0] for 8'h01 and its next two states (first = 1); t_en has no effect.
REQ-038 SHALL pass: reset asserted in the cycle after q_en -> v_valid=0 and all sets return way 0 on the next query.
